// File: rtl/bht_local_hist_predictor_pkg.sv
// Shared types and constants for the local-history branch history table.
package bht_local_hist_predictor_pkg;

  localparam int unsigned BHT_NR_ENTRIES = 32;
  localparam int unsigned BHT_HIST_BITS  = 3;
  localparam logic [1:0]  BHT_CNT_INIT   = 2'b01;

  typedef enum logic {
    INIT,
    IDLE
  } bht_state_e;

  // Layout of one table entry at the default geometry.
  typedef struct packed {
    logic                                  valid;
    logic [BHT_HIST_BITS-1:0]              hist;
    logic [2**BHT_HIST_BITS-1:0][1:0]      cnt;
  } bht_lhist_entry_t;

endpackage

// File: rtl/bht_local_hist_predictor_if.sv
// Frontend <-> BHT bus: lookup request, registered prediction, training and flush.
interface bht_local_hist_predictor_if #(
  parameter int unsigned VLEN = 32
);
  logic            flush_bp_i;
  logic            lookup_i;
  logic [VLEN-1:0] lookup_pc_i;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic            upd_valid_i;
  logic [VLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic            ready_o;

  modport master (
    output flush_bp_i, lookup_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    input  pred_valid_o, pred_taken_o, ready_o
  );

  modport slave (
    input  flush_bp_i, lookup_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    output pred_valid_o, pred_taken_o, ready_o
  );
endinterface

// File: rtl/bht_local_hist_predictor_sat_counter2.sv
// Combinational 2-bit saturating up/down counter used on the BHT training path.
module bht_local_hist_predictor_sat_counter2 (
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != 2'b11) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != 2'b00) cnt_o = cnt_i - 2'd1;
    end
  end
endmodule

// File: rtl/bht_local_hist_predictor.sv
// Local-history BHT: PC-indexed history per entry selecting one of 2**HIST_BITS 2-bit counters.
module bht_local_hist_predictor
  import bht_local_hist_predictor_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = BHT_NR_ENTRIES,
  parameter int unsigned HIST_BITS  = BHT_HIST_BITS,
  parameter int unsigned VLEN       = 32,
  parameter int unsigned PC_OFFSET  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  bht_local_hist_predictor_if.slave   bp
);

  localparam int unsigned IDX_W  = $clog2(NR_ENTRIES);
  localparam int unsigned NR_CNT = 2**HIST_BITS;

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NR_ENTRIES - 1);

  logic [NR_ENTRIES-1:0] valid_q;
  logic [HIST_BITS-1:0]  hist_q [NR_ENTRIES];
  logic [1:0]            cnt_q  [NR_ENTRIES][NR_CNT];

  bht_state_e state_q;
  idx_t       clr_ptr_q;
  logic       ready_q;
  logic       pred_valid_q;
  logic       pred_taken_q;

  idx_t                 lk_idx;
  idx_t                 up_idx;
  logic                 lk_en;
  logic                 up_en;
  logic [1:0]           lk_cnt;
  logic [HIST_BITS-1:0] up_hist;
  logic [HIST_BITS-1:0] up_hist_next;
  logic [1:0]           up_cnt;
  logic [1:0]           up_cnt_next;
  logic [VLEN-1:0]      unused_pc_bits;

  assign lk_idx = bp.lookup_pc_i[PC_OFFSET +: IDX_W];
  assign up_idx = bp.upd_pc_i[PC_OFFSET +: IDX_W];
  assign lk_en  = (state_q == IDLE) && bp.lookup_i && !bp.flush_bp_i;
  assign up_en  = (state_q == IDLE) && bp.upd_valid_i && !bp.flush_bp_i;
  assign unused_pc_bits = bp.lookup_pc_i ^ bp.upd_pc_i;

  // Reads see the registered table, so a same-cycle update is invisible to the lookup.
  assign lk_cnt = cnt_q[lk_idx][hist_q[lk_idx]];

  // An invalid entry trains as if freshly loaded with hist=0 and all counters weakly not-taken.
  always_comb begin
    up_hist = '0;
    up_cnt  = BHT_CNT_INIT;
    if (valid_q[up_idx]) begin
      up_hist = hist_q[up_idx];
      up_cnt  = cnt_q[up_idx][hist_q[up_idx]];
    end
    up_hist_next = {up_hist[HIST_BITS-2:0], bp.upd_taken_i};
  end

  bht_local_hist_predictor_sat_counter2 u_sat_counter2 (
    .cnt_i (up_cnt),
    .inc_i (bp.upd_taken_i),
    .cnt_o (up_cnt_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= INIT;
      clr_ptr_q    <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= lk_en && valid_q[lk_idx];
      pred_taken_q <= lk_en && valid_q[lk_idx] && lk_cnt[1];
      if (bp.flush_bp_i) begin
        state_q   <= INIT;
        clr_ptr_q <= '0;
        ready_q   <= 1'b0;
      end else begin
        unique case (state_q)
          INIT: begin
            valid_q[clr_ptr_q] <= 1'b0;
            clr_ptr_q          <= clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
              state_q   <= IDLE;
              clr_ptr_q <= '0;
              ready_q   <= 1'b1;
            end
          end
          IDLE: begin
            if (up_en) valid_q[up_idx] <= 1'b1;
          end
        endcase
      end
    end
  end

  // History and counters carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (up_en) begin
      if (!valid_q[up_idx]) begin
        for (int unsigned i = 0; i < NR_CNT; i++) cnt_q[up_idx][i] <= BHT_CNT_INIT;
      end
      cnt_q[up_idx][up_hist] <= up_cnt_next;
      hist_q[up_idx]         <= up_hist_next;
    end
  end

  assign bp.pred_valid_o = pred_valid_q;
  assign bp.pred_taken_o = pred_taken_q;
  assign bp.ready_o      = ready_q;

endmodule

// File: tb/tb_bht_local_hist_predictor.sv
// Self-checking bench for bht_local_hist_predictor against an array-based predictor model.
module tb_bht_local_hist_predictor;

  localparam logic [31:0] PC8  = 32'h8000_0010;
  localparam logic [31:0] PC8A = 32'h1234_0010;
  localparam logic [31:0] PC16 = 32'h8000_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bht_local_hist_predictor_if #(.VLEN(32)) bp ();

  bht_local_hist_predictor #(
    .NR_ENTRIES (32),
    .HIST_BITS  (3),
    .VLEN       (32),
    .PC_OFFSET  (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a table of small integers plus a countdown for the clear sweep.
  bit m_valid [32];
  int m_hist  [32];
  int m_cnt   [32][8];
  bit m_ready;
  int m_left;
  bit exp_pv, exp_pt, exp_rdy;

  function automatic int pc_idx(input logic [31:0] pc);
    return (int'(pc) >>> 1) & 31;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_ready = 1'b0;
    m_left  = 32;
  endtask

  // Drive one cycle, advance the model, and sample #1 after the edge.
  task automatic step(input bit lk, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input bit ut, input bit fl);
    int li, ui, h, c;
    bp.lookup_i    = lk;
    bp.lookup_pc_i = lpc;
    bp.upd_valid_i = uv;
    bp.upd_pc_i    = upc;
    bp.upd_taken_i = ut;
    bp.flush_bp_i  = fl;
    li = pc_idx(lpc);
    ui = pc_idx(upc);
    exp_pv = 1'b0;
    exp_pt = 1'b0;
    if (m_ready && lk && !fl) begin
      exp_pv = m_valid[li];
      exp_pt = m_valid[li] && (m_cnt[li][m_hist[li]] >= 2);
    end
    if (m_ready && uv && !fl) begin
      if (!m_valid[ui]) begin
        m_hist[ui] = 0;
        for (int k = 0; k < 8; k++) m_cnt[ui][k] = 1;
        m_valid[ui] = 1'b1;
      end
      h = m_hist[ui];
      c = m_cnt[ui][h];
      m_cnt[ui][h] = ut ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      m_hist[ui] = ((h * 2) + (ut ? 1 : 0)) % 8;
    end
    if (fl) begin
      model_clear();
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end
    exp_rdy = m_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int zeros, bad;
    rst = 1'b1;
    bp.lookup_i = 1'b0; bp.upd_valid_i = 1'b0; bp.flush_bp_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if ({bp.ready_o, bp.pred_valid_o, bp.pred_taken_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=000", {bp.ready_o, bp.pred_valid_o, bp.pred_taken_o});
    end
    rst = 1'b0;
    model_clear();
    zeros = 1;
    bad   = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), 1'b0);
      if (bp.ready_o === 1'b1) break;
      zeros++;
      if (bp.pred_valid_o !== 1'b0) bad++;
    end
    n_tests++;
    if (zeros !== 32) begin
      n_fail++;
      $display("FAIL reset_sweep_len got=%0d want=32", zeros);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_sweep_lookup got=%0d valid predictions want=0", bad);
    end
    n_tests++;
    if (bp.ready_o !== exp_rdy) begin
      n_fail++;
      $display("FAIL reset_ready_after got=%b want=%b", bp.ready_o, exp_rdy);
    end
  endtask

  task automatic test_cold_lookup();
    step(1'b1, PC8, 1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL cold_lookup got=%b%b want=00", bp.pred_valid_o, bp.pred_taken_o);
    end
  endtask

  task automatic test_training();
    step(1'b0, '0, 1'b1, PC8, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, PC8, 1'b1, 1'b0);
    step(1'b1, PC8, 1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b10 || {exp_pv, exp_pt} !== 2'b10) begin
      n_fail++;
      $display("FAIL train_hist011 got=%b%b model=%b%b want=10", bp.pred_valid_o,
               bp.pred_taken_o, exp_pv, exp_pt);
    end
    repeat (3) step(1'b0, '0, 1'b1, PC8, 1'b1, 1'b0);
    step(1'b1, PC8A, 1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b11 || {exp_pv, exp_pt} !== 2'b11) begin
      n_fail++;
      $display("FAIL train_hist111 got=%b%b model=%b%b want=11", bp.pred_valid_o,
               bp.pred_taken_o, exp_pv, exp_pt);
    end
  endtask

  task automatic test_saturation();
    repeat (6) step(1'b0, '0, 1'b1, PC16, 1'b0, 1'b0);
    step(1'b1, PC16, 1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL sat_floor got=%b%b want=10", bp.pred_valid_o, bp.pred_taken_o);
    end
  endtask

  task automatic test_same_cycle();
    // idx 8 leaves training with hist=111; three not-taken bring hist to 000 where cnt[0]=10.
    repeat (3) step(1'b0, '0, 1'b1, PC8, 1'b0, 1'b0);
    step(1'b1, PC8, 1'b1, PC8, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b11 || {exp_pv, exp_pt} !== 2'b11) begin
      n_fail++;
      $display("FAIL same_cycle_old got=%b%b model=%b%b want=11", bp.pred_valid_o,
               bp.pred_taken_o, exp_pv, exp_pt);
    end
    step(1'b1, PC8, 1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b10 || {exp_pv, exp_pt} !== 2'b10) begin
      n_fail++;
      $display("FAIL same_cycle_new got=%b%b model=%b%b want=10", bp.pred_valid_o,
               bp.pred_taken_o, exp_pv, exp_pt);
    end
  endtask

  task automatic test_flush_sweep();
    int zeros;
    step(1'b1, PC8, 1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if ({bp.ready_o, bp.pred_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_idle got=%b%b want=00", bp.ready_o, bp.pred_valid_o);
    end
    repeat (9) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    zeros = 1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, PC8, 1'b1, PC8, 1'b1, 1'b0);
      if (bp.ready_o === 1'b1) break;
      zeros++;
    end
    n_tests++;
    if (zeros !== 32) begin
      n_fail++;
      $display("FAIL flush_restart_len got=%0d want=32", zeros);
    end
    step(1'b1, PC8, 1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if ({bp.pred_valid_o, bp.pred_taken_o} !== 2'b00 || exp_pv !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_update_ignored got=%b%b want=00", bp.pred_valid_o, bp.pred_taken_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs [5];
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      pcs[0] = PC8; pcs[1] = PC8A; pcs[2] = PC16; pcs[3] = 32'h8000_003e; pcs[4] = $urandom;
      step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
      n_tests++;
      if ({bp.pred_valid_o, bp.pred_taken_o, bp.ready_o} !== {exp_pv, exp_pt, exp_rdy}) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got=%b%b%b want=%b%b%b", i, bp.pred_valid_o,
                   bp.pred_taken_o, bp.ready_o, exp_pv, exp_pt, exp_rdy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bp.lookup_i = 1'b0; bp.lookup_pc_i = '0; bp.upd_valid_i = 1'b0;
    bp.upd_pc_i = '0; bp.upd_taken_i = 1'b0; bp.flush_bp_i = 1'b0;
    test_reset();
    test_cold_lookup();
    test_training();
    test_saturation();
    test_same_cycle();
    test_flush_sweep();
    test_random();
    // Reset in the middle of random traffic must clear the whole table again.
    test_reset();
    test_cold_lookup();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
